// File: rtl/mult_final_adder_pkg.sv
// Shared constants for the multiplier final carry-propagate stage.
// The product width follows the radix-4 Booth multiplier operand widths.
package mult_final_adder_pkg;

    localparam int MULT_WIDTH_A = 16;
    localparam int MULT_WIDTH_B = 16;
    localparam int MULT_WIDTH_O = MULT_WIDTH_A + MULT_WIDTH_B;

endpackage

// File: rtl/mult_final_adder_cpa_slice.sv
// Combinational ripple/carry-propagate adder slice with carry in and carry out.
module mult_final_adder_cpa_slice #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full_s;

    // Zero-extend both operands so the top bit captures the carry out.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

    assign sum  = full_s[WIDTH-1:0];
    assign cout = full_s[WIDTH];

endmodule

// File: rtl/mult_final_adder.sv
// Two-stage pipelined resolution of a CSA sum/carry pair into a binary product,
// with valid/ready handshakes on both sides and a synchronous flush.
module mult_final_adder
    import mult_final_adder_pkg::*;
#(
    parameter int WIDTH_O = MULT_WIDTH_O,
    parameter int SPLIT   = WIDTH_O / 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH_O-1:0] sum_i,
    input  logic [WIDTH_O-1:0] carry_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH_O-1:0] product_o,
    output logic               zero_o
);

    localparam int HI_W = WIDTH_O - SPLIT;

    logic               va_q, va_d;
    logic [SPLIT-1:0]   lo_q, lo_d;
    logic               cy_q, cy_d;
    logic [HI_W-1:0]    hi_sum_q, hi_sum_d;
    logic [HI_W-1:0]    hi_car_q, hi_car_d;
    logic               vb_q, vb_d;
    logic [WIDTH_O-1:0] product_q, product_d;
    logic               zero_q, zero_d;

    logic               ready_a_s;
    logic               ready_b_s;
    logic [SPLIT-1:0]   lo_sum_s;
    logic               lo_cout_s;
    logic [HI_W-1:0]    hi_res_s;
    logic               hi_cout_unused_s;
    logic [WIDTH_O-1:0] result_s;

    mult_final_adder_cpa_slice #(.WIDTH(SPLIT)) u_cpa_lo (
        .a    (sum_i[SPLIT-1:0]),
        .b    (carry_i[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum_s),
        .cout (lo_cout_s)
    );

    // The carry out of the top bit is the modular wrap and is discarded.
    mult_final_adder_cpa_slice #(.WIDTH(HI_W)) u_cpa_hi (
        .a    (hi_sum_q),
        .b    (hi_car_q),
        .cin  (cy_q),
        .sum  (hi_res_s),
        .cout (hi_cout_unused_s)
    );

    assign result_s  = {hi_res_s, lo_q};
    assign ready_b_s = ~vb_q | out_ready_i;
    assign ready_a_s = ~va_q | ready_b_s;

    // Stage A next state: capture low-slice sum and raw upper halves on accept.
    always_comb begin
        va_d     = va_q;
        lo_d     = lo_q;
        cy_d     = cy_q;
        hi_sum_d = hi_sum_q;
        hi_car_d = hi_car_q;
        if (flush_i) begin
            va_d = 1'b0;
        end else if (ready_a_s) begin
            va_d = in_valid_i;
            if (in_valid_i) begin
                lo_d     = lo_sum_s;
                cy_d     = lo_cout_s;
                hi_sum_d = sum_i[WIDTH_O-1:SPLIT];
                hi_car_d = carry_i[WIDTH_O-1:SPLIT];
            end else begin
                lo_d = lo_q;
            end
        end else begin
            va_d = va_q;
        end
    end

    // Stage B next state: finish the high slice when stage A advances.
    always_comb begin
        vb_d      = vb_q;
        product_d = product_q;
        zero_d    = zero_q;
        if (flush_i) begin
            vb_d = 1'b0;
        end else if (ready_b_s) begin
            vb_d = va_q;
            if (va_q) begin
                product_d = result_s;
                zero_d    = (result_s == {WIDTH_O{1'b0}});
            end else begin
                product_d = product_q;
            end
        end else begin
            vb_d = vb_q;
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            va_q      <= 1'b0;
            lo_q      <= {SPLIT{1'b0}};
            cy_q      <= 1'b0;
            hi_sum_q  <= {HI_W{1'b0}};
            hi_car_q  <= {HI_W{1'b0}};
            vb_q      <= 1'b0;
            product_q <= {WIDTH_O{1'b0}};
            zero_q    <= 1'b0;
        end else begin
            va_q      <= va_d;
            lo_q      <= lo_d;
            cy_q      <= cy_d;
            hi_sum_q  <= hi_sum_d;
            hi_car_q  <= hi_car_d;
            vb_q      <= vb_d;
            product_q <= product_d;
            zero_q    <= zero_d;
        end
    end

    assign in_ready_o  = ready_a_s;
    assign out_valid_o = vb_q;
    assign product_o   = product_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_mult_final_adder.sv
// Scoreboard bench for mult_final_adder using directed, hand-computed vectors.
module tb_mult_final_adder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] sum_i;
    logic [31:0] carry_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] product_o;
    logic        zero_o;

    int tests  = 0;
    int failed = 0;
    logic [32:0] exp_q[$];

    logic [31:0] str_s [8] = '{32'h00000001, 32'h12345678, 32'h0000FFFF, 32'hFFFF0000,
                               32'h7FFFFFFF, 32'hAAAAAAAA, 32'hDEADBEEF, 32'h00008000};
    logic [31:0] str_c [8] = '{32'h00000002, 32'h11111111, 32'h0000FFFF, 32'h00010000,
                               32'h00000001, 32'h55555555, 32'h00000000, 32'h00008000};
    logic [31:0] str_e [8] = '{32'h00000003, 32'h23456789, 32'h0001FFFE, 32'h00000000,
                               32'h80000000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h00010000};
    logic [31:0] bp_s [5] = '{32'h00000010, 32'h00000100, 32'h00001000, 32'h00010000, 32'h00100000};
    logic [31:0] bp_c [5] = '{32'h00000020, 32'h00000200, 32'h00002000, 32'h00020000, 32'h00200000};
    logic [31:0] bp_e [5] = '{32'h00000030, 32'h00000300, 32'h00003000, 32'h00030000, 32'h00300000};

    mult_final_adder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sum_i       (sum_i),
        .carry_i     (carry_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .product_o   (product_o),
        .zero_o      (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector and hold it until accepted; push the expected result on accept.
    task automatic send(input logic [31:0] s, input logic [31:0] c, input logic [31:0] e,
                        output int waits);
        logic rdy;
        logic done;
        done  = 1'b0;
        waits = 0;
        in_valid_i = 1'b1;
        sum_i      = s;
        carry_i    = c;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            rdy = in_ready_o;
            @(posedge clk_i);
            #1;
            if (rdy) begin
                exp_q.push_back({(e == 32'h0), e});
                done = 1'b1;
                break;
            end
            waits++;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i);
            #1;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    // Monitor: every output transfer must match the oldest expected entry.
    always @(negedge clk_i) begin
        logic [32:0] ent;
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", product_o, 32'hxxxxxxxx);
            end else begin
                ent = exp_q.pop_front();
                check("product", product_o, ent[31:0]);
                check("zero", {31'd0, zero_o}, {31'd0, ent[32]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int acc;
        logic rdy;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        sum_i       = 32'h0;
        carry_i     = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_product", product_o, 32'h0);
        check("rst_zero", {31'd0, zero_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

        // Carry across the slice boundary, then modular wrap-around.
        send(32'h0000FFFF, 32'h00000001, 32'h00010000, w);
        send(32'hFFFFFFFF, 32'h00000001, 32'h00000000, w);
        send(32'h80000000, 32'h80000000, 32'h00000000, w);
        in_valid_i = 1'b0;
        wait_drain();

        // Streaming with two-cycle latency and no stalls.
        for (int i = 0; i < 8; i++) begin
            send(str_s[i], str_c[i], str_e[i], w);
            check("stream_no_wait", w, 32'd0);
            if (i == 0) check("latency_early", {31'd0, out_valid_o}, 32'd0);
            if (i == 1) check("latency_first", {31'd0, out_valid_o}, 32'd1);
        end
        in_valid_i = 1'b0;
        wait_drain();

        // Backpressure: only two entries fit, output held stable.
        out_ready_i = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid_i = 1'b1;
            sum_i      = bp_s[acc];
            carry_i    = bp_c[acc];
            @(negedge clk_i);
            rdy = in_ready_o;
            @(posedge clk_i);
            #1;
            if (rdy && acc < 4) begin
                exp_q.push_back({1'b0, bp_e[acc]});
                acc++;
            end
            if (cyc >= 2) begin
                check("bp_hold_product", product_o, 32'h00000030);
                check("bp_hold_valid", {31'd0, out_valid_o}, 32'd1);
            end
        end
        check("bp_accepted", acc, 32'd2);
        check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        wait_drain();

        // Flush a full pipeline; flushed values must never be presented.
        out_ready_i = 1'b0;
        send(32'hCAFE0000, 32'h0000BABE, 32'hCAFEBABE, w);
        send(32'h11110000, 32'h00002222, 32'h11112222, w);
        in_valid_i = 1'b0;
        check("flush_full", {31'd0, in_ready_o}, 32'd0);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("flush_inflight", exp_q.size(), 32'd2);
        exp_q.delete();
        out_ready_i = 1'b1;
        // An input offered in the flush cycle is dropped too.
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        sum_i      = 32'h00000005;
        carry_i    = 32'h00000006;
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            check("flush_quiet", {31'd0, out_valid_o}, 32'd0);
        end

        // Asynchronous reset mid-stream.
        send(32'h00000001, 32'h00000001, 32'h00000002, w);
        send(32'h00000002, 32'h00000002, 32'h00000004, w);
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid_o}, 32'd0);
        exp_q.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_ready", {31'd0, in_ready_o}, 32'd1);
        send(32'h00001234, 32'h00004321, 32'h00005555, w);
        in_valid_i = 1'b0;
        wait_drain();

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mult_final_adder.md
Name: mult_final_adder

Overview:
- Pipelined carry-propagate stage placed directly downstream of the radix-4 Booth multiplier.
- Consumes the redundant sum/carry pair produced by the multiplier's CSA tree and resolves it into a binary product.
- Splits the addition into two registered half-width slices to meet timing at the dot-product datapath clock.
- Uses valid/ready handshakes on both sides so the posit pipeline can stall it.

Parameters:
- WIDTH_O, 32, bit-width of sum_i, carry_i and product_o (equals WIDTH_A+WIDTH_B of the multiplier).
- SPLIT, WIDTH_O/2, bit position of the low/high slice boundary; legal range 1..WIDTH_O-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; drops all in-flight data.
- in_valid_i  in  1  sum_i/carry_i valid.
- in_ready_o  out  1  stage can accept this cycle.
- sum_i  in  WIDTH_O  CSA sum vector.
- carry_i  in  WIDTH_O  CSA carry vector, already weight-aligned (no shift applied here).
- out_valid_o  out  1  product_o valid.
- out_ready_i  in  1  downstream accepts product.
- product_o  out  WIDTH_O  (sum_i + carry_i) mod 2^WIDTH_O.
- zero_o  out  1  product_o == 0, valid with out_valid_o.

Behaviour:
- Clock and reset: single clock clk_i; reset is asynchronous, active-low on rst_ni.
- Reset values: all valid flags 0, so out_valid_o=0. product_o, zero_o and internal data registers are 0. in_ready_o=1 once reset is released.
- Arithmetic: unsigned modular addition, carry out of bit WIDTH_O-1 discarded. No sign handling; sign extension was resolved upstream.
- Stage A (registered on accept):
  - lo_q = sum_i[SPLIT-1:0] + carry_i[SPLIT-1:0].
  - cy_q = carry out of that addition.
  - hi_sum_q and hi_car_q hold the upper WIDTH_O-SPLIT bits of each input.
  - vA = 1.
- Stage B (registered when A advances):
  - product_q = {hi_sum_q + hi_car_q + cy_q, lo_q}.
  - zero_q = (product_q == 0), computed from the next-state value.
  - vB = 1.
- Latency: data accepted at rising edge t appears on product_o with out_valid_o=1 after edge t+1 (2-cycle latency).
- Throughput: 1 result/cycle when out_ready_i stays high.
- Handshake:
  - readyB = !vB | out_ready_i; readyA = !vA | readyB; in_ready_o = readyA (combinational chain).
  - A stage loads when its ready is high. A stage's valid clears when it is consumed and not refilled.
  - product_o, zero_o and out_valid_o hold stable while out_valid_o=1 and out_ready_i=0.
  - in_valid_i may drop without a transfer. in_ready_o never depends on in_valid_i.
- Full pipeline (vA=vB=1, out_ready_i=0): in_ready_o=0 and no register changes.
- Simultaneous output consume and input accept: both occur in the same cycle, with no bubble inserted.
- flush_i=1 at an edge: vA and vB clear, and any input offered that cycle is dropped. in_ready_o is still reported normally. Data registers need not clear.
- Reset asserted mid-operation: all valid flags clear immediately (asynchronously); the in-flight result is lost, with no partial output.
- SPLIT boundary: a carry generated exactly at bit SPLIT-1 must propagate into the high slice.

Decomposition:
- Shared package: no new typedefs. The default WIDTH_O is derived from the multiplier width constant already in the PDPU package.
- Sub-module cpa_slice: combinational adder with parameter WIDTH and ports a, b, cin, sum, cout.
  - Instanced once for the low slice with cin=0.
  - Instanced once for the high slice with cin=cy_q.

Test Plan:
- Carry across split: sum_i=0x0000FFFF, carry_i=0x00000001, out_ready_i=1 -> product_o=0x00010000 two cycles later, zero_o=0.
- Wrap-around: sum_i=0xFFFFFFFF, carry_i=0x00000001 -> product_o=0x00000000, zero_o=1. Then sum_i=0x80000000, carry_i=0x80000000 -> product_o=0x00000000, zero_o=1.
- Streaming: 8 back-to-back inputs, out_ready_i=1 -> 8 consecutive out_valid_o cycles starting 2 cycles after the first accept, in order. in_ready_o stays 1 throughout.
- Backpressure: out_ready_i=0 for 5 cycles while in_valid_i=1 -> exactly 2 inputs accepted, then in_ready_o=0. product_o is held. On release the results drain in order with no loss or duplication.
- Flush: flush_i pulsed while vA=vB=1 -> out_valid_o=0 next cycle, and the flushed values never appear at the output.
- Reset mid-stream: rst_ni driven low asynchronously between edges -> out_valid_o=0 immediately. After release, in_ready_o=1 and a fresh input 0x1234+0x4321 yields 0x5555.
